rob_wb_arb: RTL and testbench

Writeback arbiter directly upstream of the retire stage. Collects completed-uop results from `NUM_EU` execution units, buffers each in a per-unit FIFO, and picks one result per cycle with round-robin arbitration. The winner is presented to retire on the registered `ro_valid_rb0` / `ro_result_rb0` pair. All buffered results are discarded on a branch mispredict flush from retire.

---
 rtl/rob_wb_arb_if.sv | 24 ++
 rtl/rob_wb_arb.sv | 104 ++++++++++
 tb/tb_rob_wb_arb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rob_wb_arb_if.sv
// rob_wb_arb_if: result payload type and the writeback bus between execution units, arbiter and retire.
package rob_defs;
    typedef struct packed {
        logic [5:0]  robid;
        logic [15:0] data;
    } t_rob_result;
endpackage

interface rob_wb_arb_if #(parameter int NUM_EU = 2);
    logic [NUM_EU-1:0]                  eu_valid_ex;
    rob_defs::t_rob_result [NUM_EU-1:0] eu_result_ex;
    logic [NUM_EU-1:0]                  eu_rdy_ex;
    logic                               br_mispred_rb1;
    logic                               ro_valid_rb0;
    rob_defs::t_rob_result              ro_result_rb0;
    modport master (
        output eu_valid_ex, eu_result_ex, br_mispred_rb1,
        input  eu_rdy_ex, ro_valid_rb0, ro_result_rb0
    );
    modport slave (
        input  eu_valid_ex, eu_result_ex, br_mispred_rb1,
        output eu_rdy_ex, ro_valid_rb0, ro_result_rb0
    );
endinterface

// File: rtl/rob_wb_arb.sv
// rob_wb_arb: per-source writeback FIFOs with a round-robin pick into a registered retire port.
// Define ROB_WB_ARB_BYPASS_EN to let an empty source's live input win arbitration directly.
module rob_wb_arb #(
    parameter int NUM_EU     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    rob_wb_arb_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(NUM_EU);

    rob_defs::t_rob_result   r_mem [NUM_EU][FIFO_DEPTH];
    logic [NUM_EU-1:0][AW:0] r_wp, r_rp;
    logic [IW-1:0]           r_rr;
    logic                    r_valid;
    rob_defs::t_rob_result   r_result;

    logic [NUM_EU-1:0]     w_empty, w_full, w_req, w_push, w_pop, w_bsel;
    logic                  w_flush, w_gnt, w_byp;
    logic [IW-1:0]         w_win, w_nrr;
    rob_defs::t_rob_result w_head;

    assign w_flush = bus.br_mispred_rb1;

    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int i = 0; i < NUM_EU; i++) begin
            w_empty[i] = r_wp[i] == r_rp[i];
            w_full[i]  = r_wp[i][AW-1:0] == r_rp[i][AW-1:0] && r_wp[i][AW] != r_rp[i][AW];
        end
    end

`ifdef ROB_WB_ARB_BYPASS_EN
    assign w_req = (~w_empty | bus.eu_valid_ex) & {NUM_EU{!w_flush}};
    assign w_byp = w_gnt && w_empty[w_win];
`else
    assign w_req = ~w_empty & {NUM_EU{!w_flush}};
    assign w_byp = 1'b0;
`endif

    // Scan downward so the requester closest at-or-after r_rr is the last to overwrite.
    always_comb begin
        w_gnt = 1'b0;
        w_win = '0;
        for (int k = NUM_EU - 1; k >= 0; k--)
            if (w_req[(int'(r_rr) + k) % NUM_EU]) begin
                w_gnt = 1'b1;
                w_win = IW'((int'(r_rr) + k) % NUM_EU);
            end
    end

    assign w_nrr  = (w_win == IW'(NUM_EU - 1)) ? '0 : w_win + 1'b1;
    assign w_bsel = w_byp ? NUM_EU'(1) << w_win : '0;
    assign w_pop  = (w_gnt && !w_byp) ? NUM_EU'(1) << w_win : '0;
    assign w_push = bus.eu_valid_ex & ~w_full & ~w_bsel & {NUM_EU{!w_flush}};
    assign w_head = w_byp ? bus.eu_result_ex[w_win] : r_mem[w_win][r_rp[w_win][AW-1:0]];

    assign bus.eu_rdy_ex     = ~w_full;
    assign bus.ro_valid_rb0  = r_valid;
    assign bus.ro_result_rb0 = r_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_rr     <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= w_gnt;
            if (w_gnt)
                r_result <= w_head;
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
                r_rr <= '0;
            end else begin
                if (w_gnt)
                    r_rr <= w_nrr;
                for (int i = 0; i < NUM_EU; i++) begin
                    if (w_push[i])
                        r_wp[i] <= r_wp[i] + 1'b1;
                    if (w_pop[i])
                        r_rp[i] <= r_rp[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NUM_EU; i++)
            if (w_push[i])
                r_mem[i][r_wp[i][AW-1:0]] <= bus.eu_result_ex[i];

`ifdef ASSERT
    always_ff @(posedge clk)
        if (!reset)
            assert (!(|(bus.eu_valid_ex & ~bus.eu_rdy_ex)))
            else $warning("rob_wb_arb: valid while not ready, result dropped");
`endif
endmodule

// File: tb/tb_rob_wb_arb.sv
// tb_rob_wb_arb: directed vector table plus hand-written sequences for rob_wb_arb (NUM_EU=2, FIFO_DEPTH=4).
module tb_rob_wb_arb;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   got[$];

    rob_wb_arb_if #(.NUM_EU(2)) bus();
    rob_wb_arb #(.NUM_EU(2), .FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] v;
        int         r0;
        int         r1;
        logic       ev;
        int         er;
        logic [1:0] erdy;
    } t_vec;
    t_vec vec[16];

    function automatic rob_defs::t_rob_result mk(int r);
        mk.robid = 6'(r);
        mk.data  = 16'hA000 | 16'(r);
    endfunction

    task automatic chk(string nm, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic drive(logic [1:0] v, int r0, int r1, logic fl);
        bus.eu_valid_ex     = v;
        bus.eu_result_ex[0] = mk(r0);
        bus.eu_result_ex[1] = mk(r1);
        bus.br_mispred_rb1  = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.ro_valid_rb0)
            got.push_back(int'(bus.ro_result_rb0.robid));
    endtask

    task automatic do_reset();
        drive(2'b00, 0, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        got.delete();
    endtask

    task automatic chk_got(string nm, int want[$]);
        chk($sformatf("%s_count", nm), got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("%s_%0d", nm, i), i < got.size() ? got[i] : -1, want[i]);
    endtask

    initial begin
        vec[0]  = '{2'b11, 0, 32, 1'b0, 0,  2'b11};
        vec[1]  = '{2'b11, 1, 33, 1'b1, 0,  2'b11};
        vec[2]  = '{2'b11, 2, 34, 1'b1, 32, 2'b11};
        vec[3]  = '{2'b11, 3, 35, 1'b1, 1,  2'b11};
        vec[4]  = '{2'b11, 4, 36, 1'b1, 33, 2'b11};
        vec[5]  = '{2'b11, 5, 37, 1'b1, 2,  2'b01};
        vec[6]  = '{2'b01, 6, 0,  1'b1, 34, 2'b10};
        vec[7]  = '{2'b10, 0, 38, 1'b1, 3,  2'b01};
        vec[8]  = '{2'b00, 0, 0,  1'b1, 35, 2'b11};
        vec[9]  = '{2'b00, 0, 0,  1'b1, 4,  2'b11};
        vec[10] = '{2'b00, 0, 0,  1'b1, 36, 2'b11};
        vec[11] = '{2'b00, 0, 0,  1'b1, 5,  2'b11};
        vec[12] = '{2'b00, 0, 0,  1'b1, 37, 2'b11};
        vec[13] = '{2'b00, 0, 0,  1'b1, 6,  2'b11};
        vec[14] = '{2'b00, 0, 0,  1'b1, 38, 2'b11};
        vec[15] = '{2'b00, 0, 0,  1'b0, 0,  2'b11};

        drive(2'b00, 0, 0, 1'b0);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_valid", int'(bus.ro_valid_rb0), 0);
        chk("reset_result", int'(bus.ro_result_rb0), 0);
        chk("reset_rdy", int'(bus.eu_rdy_ex), 3);

        // Both sources pushing: strict alternation, rdy drops at four entries
        for (int i = 0; i < 16; i++) begin
            drive(vec[i].v, vec[i].r0, vec[i].r1, 1'b0);
            cyc();
            chk($sformatf("row%0d_valid", i), int'(bus.ro_valid_rb0), int'(vec[i].ev));
            if (vec[i].ev)
                chk($sformatf("row%0d_result", i), int'(bus.ro_result_rb0), int'(mk(vec[i].er)));
            chk($sformatf("row%0d_rdy", i), int'(bus.eu_rdy_ex), int'(vec[i].erdy));
        end

        // Single-source latency: push at N, visible after edge N+1 only
        drive(2'b01, 5, 0, 1'b0);
        cyc();
        chk("lat_n_valid", int'(bus.ro_valid_rb0), 0);
        drive(2'b00, 0, 0, 1'b0);
        cyc();
        chk("lat_n1_valid", int'(bus.ro_valid_rb0), 1);
        chk("lat_n1_robid", int'(bus.ro_result_rb0.robid), 5);
        cyc();
        chk("lat_n2_valid", int'(bus.ro_valid_rb0), 0);
        chk("lat_empty_rdy", int'(bus.eu_rdy_ex), 3);

        // Fill source 1, then present a result while it is not ready
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, i, 32 + i, 1'b0);
            cyc();
        end
        chk("fill_rdy", int'(bus.eu_rdy_ex), 1);
        drive(2'b10, 0, 63, 1'b0);
        cyc();
        chk("viol_rdy", int'(bus.eu_rdy_ex), 3);
        drive(2'b00, 0, 0, 1'b0);
        repeat (9) cyc();
        chk_got("viol_order", '{0, 32, 1, 33, 2, 34, 3, 35, 4, 36, 5, 37});

        // Flush with 3 entries per FIFO, rr_ptr at 1, and a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, i, 32 + i, 1'b0);
            cyc();
        end
        drive(2'b01, 5, 0, 1'b0);
        cyc();
        chk("preflush_valid", int'(bus.ro_valid_rb0), 1);
        chk("preflush_robid", int'(bus.ro_result_rb0.robid), 2);
        drive(2'b11, 50, 51, 1'b1);
        cyc();
        chk("flush_valid", int'(bus.ro_valid_rb0), 0);
        chk("flush_rdy", int'(bus.eu_rdy_ex), 3);
        drive(2'b00, 0, 0, 1'b0);
        got.delete();
        repeat (3) cyc();
        chk("flush_drain_count", got.size(), 0);
        drive(2'b11, 7, 39, 1'b0);
        cyc();
        drive(2'b00, 0, 0, 1'b0);
        cyc();
        chk("postflush_first", int'(bus.ro_result_rb0.robid), 7);
        cyc();
        chk("postflush_second", int'(bus.ro_result_rb0.robid), 39);

        // Asynchronous reset between edges with a full FIFO
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, i, 32 + i, 1'b0);
            cyc();
        end
        drive(2'b01, 6, 0, 1'b0);
        cyc();
        drive(2'b00, 0, 0, 1'b0);
        chk("prerst_valid", int'(bus.ro_valid_rb0), 1);
        chk("prerst_rdy", int'(bus.eu_rdy_ex), 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", int'(bus.ro_valid_rb0), 0);
        chk("arst_rdy", int'(bus.eu_rdy_ex), 3);
        #2 reset = 1'b0;
        cyc();
        chk("arst_after_valid", int'(bus.ro_valid_rb0), 0);

        // Pointer wrap: 3*FIFO_DEPTH results through source 0
        got.delete();
        for (int i = 0; i < 12; i++) begin
            drive(2'b01, i, 0, 1'b0);
            cyc();
        end
        drive(2'b00, 0, 0, 1'b0);
        repeat (3) cyc();
        chk_got("wrap", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
